// File: rtl/bg_fetch_sequencer.sv
// bg_fetch_sequencer: raster-scan background fetch sequencer.
// Walks the image row-major from a latched anchor, clips off-screen positions,
// reads the background ROM under a 2-credit budget and streams decoded RGB888
// pixels with screen coordinates over valid/ready.
// Optional build macro: BG_TRANSPARENCY_EN (drop ROM words equal to TRANSPARENT_KEY).
module bg_fetch_sequencer #(
    parameter int unsigned SCREEN_WIDTH    = 800,
    parameter int unsigned SCREEN_HEIGHT   = 600,
    parameter int unsigned IMAGE_WIDTH     = 640,
    parameter int unsigned IMAGE_HEIGHT    = 480,
    parameter logic [15:0] TRANSPARENT_KEY = 16'h0F0F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  anchor_x,
    input  logic [9:0]  anchor_y,
    output logic        busy,
    output logic        done,
    output logic        rom_en,
    output logic [18:0] rom_addr,
    input  logic [15:0] rom_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [7:0]  r_out,
    output logic [7:0]  g_out,
    output logic [7:0]  b_out,
    output logic [9:0]  x_out,
    output logic [9:0]  y_out
);

    localparam int unsigned COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int unsigned ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [10:0] SCR_W = 11'(SCREEN_WIDTH);
    localparam logic [10:0] SCR_H = 11'(SCREEN_HEIGHT);

`ifdef BG_TRANSPARENCY_EN
    localparam bit TRANSP_EN = 1'b1;
`else
    localparam bit TRANSP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [11:0] rgb;
        logic [9:0]  x;
        logic [9:0]  y;
    } pix_t;

    state_t           state_q,    state_d;
    logic [9:0]       anchor_x_q, anchor_x_d;
    logic [9:0]       anchor_y_q, anchor_y_d;
    logic [COL_W-1:0] col_q,      col_d;
    logic [ROW_W-1:0] row_q,      row_d;
    logic [18:0]      addr_q,     addr_d;
    logic             inflight_q, inflight_d;
    logic [9:0]       infl_x_q,   infl_x_d;
    logic [9:0]       infl_y_q,   infl_y_d;
    pix_t             fifo_q [2];
    pix_t             fifo_d [2];
    logic             rd_ptr_q,   rd_ptr_d;
    logic             wr_ptr_q,   wr_ptr_d;
    logic [1:0]       count_q,    count_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;

    logic [10:0] sx;
    logic [10:0] sy;
    logic        onscreen;
    logic [2:0]  used;
    logic        credit;
    logic        pop;
    logic        issue;
    logic        step;
    logic        last_pos;
    logic        is_key;
    logic        wr;
    pix_t        head;

    // Position evaluation, credit accounting and FIFO handshake terms
    always_comb begin
        sx       = 11'(anchor_x_q) + 11'(col_q);
        sy       = 11'(anchor_y_q) + 11'(row_q);
        onscreen = (sx < SCR_W) && (sy < SCR_H);
        pop      = (count_q != 2'd0) && pix_ready;
        // A pop this cycle frees its slot for a read issued this same cycle.
        used     = 3'(count_q) + 3'(inflight_q) - 3'(pop);
        credit   = (used < 3'd2);
        issue    = (state_q == SCAN) && onscreen && credit;
        step     = (state_q == SCAN) && (!onscreen || credit);
        last_pos = (col_q == COL_LAST) && (row_q == ROW_LAST);
        is_key   = (rom_data == TRANSPARENT_KEY);
        wr       = inflight_q && !(TRANSP_EN && is_key);
        head     = fifo_q[rd_ptr_q];
    end

    // Next-state computation for the sequencer, read tracking and output FIFO
    always_comb begin
        state_d    = state_q;
        anchor_x_d = anchor_x_q;
        anchor_y_d = anchor_y_q;
        col_d      = col_q;
        row_d      = row_q;
        addr_d     = addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        inflight_d = issue;
        infl_x_d   = infl_x_q;
        infl_y_d   = infl_y_q;
        fifo_d[0]  = fifo_q[0];
        fifo_d[1]  = fifo_q[1];
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q + 2'(wr) - 2'(pop);

        if (done_q) begin
            busy_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                // busy is still high during the done cycle, so a start there is ignored
                if (start && !busy_q) begin
                    state_d    = SCAN;
                    anchor_x_d = anchor_x;
                    anchor_y_d = anchor_y;
                    col_d      = '0;
                    row_d      = '0;
                    addr_d     = '0;
                    busy_d     = 1'b1;
                end
            end
            SCAN: begin
                if (step) begin
                    if (last_pos) begin
                        state_d = DRAIN;
                    end else begin
                        addr_d = addr_q + 19'd1;
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            row_d = row_q + ROW_W'(1);
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                end
            end
            DRAIN: begin
                if (!inflight_q && (count_q == 2'd0)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            infl_x_d = sx[9:0];
            infl_y_d = sy[9:0];
        end

        if (wr) begin
            fifo_d[wr_ptr_q] = '{rgb: rom_data[11:0], x: infl_x_q, y: infl_y_q};
            wr_ptr_d         = ~wr_ptr_q;
        end

        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    // State register with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            anchor_x_q <= '0;
            anchor_y_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            infl_x_q   <= '0;
            infl_y_q   <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            anchor_x_q <= anchor_x_d;
            anchor_y_q <= anchor_y_d;
            col_q      <= col_d;
            row_q      <= row_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            infl_x_q   <= infl_x_d;
            infl_y_q   <= infl_y_d;
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rom_en    = issue;
    assign rom_addr  = addr_q;
    assign pix_valid = (count_q != 2'd0);
    assign r_out     = {head.rgb[11:8], head.rgb[11:8]};
    assign g_out     = {head.rgb[7:4],  head.rgb[7:4]};
    assign b_out     = {head.rgb[3:0],  head.rgb[3:0]};
    assign x_out     = head.x;
    assign y_out     = head.y;

endmodule

// File: tb/tb_bg_fetch_sequencer.sv
// Testbench for bg_fetch_sequencer on a reduced 8x6 image / 20x12 screen.
module tb_bg_fetch_sequencer;

    localparam int SW = 20;
    localparam int SH = 12;
    localparam int IW = 8;
    localparam int IH = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  anchor_x = '0;
    logic [9:0]  anchor_y = '0;
    logic        busy, done, rom_en, pix_valid;
    logic [18:0] rom_addr;
    logic [15:0] rom_data = 16'hDEAD;
    logic        pix_ready = 1'b1;
    logic [7:0]  r_out, g_out, b_out;
    logic [9:0]  x_out, y_out;

    bg_fetch_sequencer #(
        .SCREEN_WIDTH (SW),
        .SCREEN_HEIGHT(SH),
        .IMAGE_WIDTH  (IW),
        .IMAGE_HEIGHT (IH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .anchor_x(anchor_x), .anchor_y(anchor_y),
        .busy(busy), .done(done), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .r_out(r_out), .g_out(g_out),
        .b_out(b_out), .x_out(x_out), .y_out(y_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int rom_mode   = 0;
    int ready_mode = 0;
    int cur_ax     = 0;
    int cur_ay     = 0;
    bit mon_en     = 1'b0;

    logic [43:0] exp_q[$];
    int issued_all = 0, acc_all = 0;
    int acc_f = 0, reads_f = 0, last_addr = -1, done_cnt = 0;
    logic [23:0] last_rgb = '0;
    bit prev_stall = 1'b0;
    logic [43:0] prev_out = '0;
    int occ, rc, rr;
    logic [43:0] got, want;

    function automatic logic [15:0] rom_word(input int a, input int mode);
        if (mode == 1) return 16'h3A5C;
        return 16'(a * 97 + 'h1234);
    endfunction

    // ROM model: one-cycle read latency, garbage when not strobed
    always @(posedge clk) rom_data <= rom_en ? rom_word(int'(rom_addr), rom_mode) : 16'hDEAD;

    // Downstream ready: always high, or low roughly one cycle in three
    initial begin
        forever begin
            @(posedge clk);
            #1;
            pix_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(2) != 0);
        end
    end

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: scoreboard pops, hold stability, credit bound, read window, done count
    always @(negedge clk) begin
        if (mon_en) begin
            got = {r_out, g_out, b_out, x_out, y_out};
            occ = issued_all + int'(rom_en) - acc_all - int'(pix_valid && pix_ready);
            total++;
            if (occ > 2) begin
                bad++;
                $display("FAIL credit outstanding=%0d max=2", occ);
            end
            if (prev_stall) begin
                total++;
                if (!pix_valid || got !== prev_out) begin
                    bad++;
                    $display("FAIL hold valid=%0b out=%h required valid=1 out=%h", pix_valid, got, prev_out);
                end
            end
            if (rom_en) begin
                rc = int'(rom_addr) % IW;
                rr = int'(rom_addr) / IW;
                total++;
                if (int'(rom_addr) >= IW * IH || cur_ax + rc >= SW || cur_ay + rr >= SH) begin
                    bad++;
                    $display("FAIL rom_win addr=%0d required on-screen position", rom_addr);
                end
                issued_all++;
                reads_f++;
                last_addr = int'(rom_addr);
            end
            if (pix_valid && pix_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_extra got=%h required none", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        bad++;
                        $display("FAIL sb_pixel got=%h required=%h", got, want);
                    end
                end
                acc_all++;
                acc_f++;
                last_rgb = {r_out, g_out, b_out};
            end
            if (done) done_cnt++;
            prev_stall = pix_valid && !pix_ready;
            prev_out   = got;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic push_expected(input int ax, input int ay, input int mode);
        logic [15:0] w;
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                if (ax + c < SW && ay + r < SH) begin
                    w = rom_word(r * IW + c, mode);
                    exp_q.push_back({{2{w[11:8]}}, {2{w[7:4]}}, {2{w[3:0]}}, 10'(ax + c), 10'(ay + r)});
                end
            end
        end
    endtask

    task automatic pulse_start(input int ax, input int ay);
        anchor_x = 10'(ax);
        anchor_y = 10'(ay);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int cyc = 0; cyc < 2000 && !seen; cyc++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout actual=no_done required=done");
        end else begin
            check("busy_at_done", busy, 1);
            @(posedge clk);
            #1;
            check("busy_after_done", {busy, done}, 2'b00);
        end
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        int ax;
        int ay;
        int rdy;
        int rom;
        int poke;
        int exp_cnt;
        int exp_last;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{0,    0,    0, 0, 0, 48, 47};
        vecs[1] = '{15,   9,    1, 0, 0, 15, 20};
        vecs[2] = '{3,    10,   1, 1, 1, 16, 15};
        vecs[3] = '{20,   0,    0, 0, 0, 0,  -1};
        vecs[4] = '{1023, 1023, 1, 0, 0, 0,  -1};
        vecs[5] = '{0,    0,    1, 0, 1, 48, 47};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {busy, done, rom_en, rom_addr, pix_valid, r_out, g_out, b_out, x_out, y_out}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        foreach (vecs[i]) begin
            ready_mode = vecs[i].rdy;
            rom_mode   = vecs[i].rom;
            cur_ax     = vecs[i].ax;
            cur_ay     = vecs[i].ay;
            acc_f = 0; reads_f = 0; last_addr = -1; done_cnt = 0;
            push_expected(cur_ax, cur_ay, rom_mode);
            pulse_start(cur_ax, cur_ay);
            check("busy_after_start", busy, 1);
            if (cur_ax < SW && cur_ay < SH)
                check("first_read", {rom_en, rom_addr}, {1'b1, 19'd0});
            if (vecs[i].poke != 0) begin
                repeat (4) @(posedge clk);
                #1;
                pulse_start(1, 1);
            end
            wait_done();
            check("pix_count", acc_f, vecs[i].exp_cnt);
            check("read_count", reads_f, vecs[i].exp_cnt);
            check("last_addr", last_addr, vecs[i].exp_last);
            check("done_once", done_cnt, 1);
            check("sb_left", exp_q.size(), 0);
            if (rom_mode == 1) check("decode_a5c", last_rgb, 24'hAA55CC);
        end

        // Reset mid-frame: outputs clear next cycle and no done follows
        ready_mode = 0;
        rom_mode   = 0;
        cur_ax = 0; cur_ay = 0;
        acc_f = 0; done_cnt = 0;
        push_expected(0, 0, 0);
        pulse_start(0, 0);
        for (int cyc = 0; cyc < 500 && acc_f < 10; cyc++) begin
            @(posedge clk);
            #1;
        end
        check("reached_pixel_10", acc_f >= 10, 1);
        mon_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_outputs", {busy, done, rom_en, rom_addr, pix_valid, r_out, g_out, b_out, x_out, y_out}, 0);
        exp_q.delete();
        issued_all = 0; acc_all = 0; done_cnt = 0;
        mon_en = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("no_done_after_rst", {done_cnt[7:0], busy}, 0);

        // Full frame after the abort
        acc_f = 0; reads_f = 0; last_addr = -1; done_cnt = 0;
        push_expected(0, 0, 0);
        pulse_start(0, 0);
        wait_done();
        check("rerun_count", acc_f, 48);
        check("rerun_done", done_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
